mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4-to-1 single-bit mux channel. Four requesters each present a request and a data bit. The block grants exactly one at a time, drives the mux select, and registers the selected bit onto the shared output. It enforces a maximum hold time so no requester can starve the others. It sits between board switch/key inputs and the LED output in the lab datapath.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/mux4_rr_arbiter_if.sv | 16 +
 rtl/mux2to1.sv | 11 +
 rtl/rr_pick.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 82 ++++++++
 tb/tb_mux4_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants for the 4-requester round-robin mux arbiter.
// Included by the interface, the priority picker and the arbiter top.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 4;

  // FSM encoding kept as plain constants so legacy code can compare raw bits
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface mux4_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               m;
  logic               busy;

  modport master (output req, data, input grant, sel, m, busy);
  modport slave  (input req, data, output grant, sel, m, busy);

endinterface

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer primitive used to build wider select trees.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request bit scanning ptr, ptr+1, ... mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    // Scan from the farthest position back to ptr so the closest match is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 single-bit channel with a bounded hold
// time; the selected data bit is registered onto m one cycle behind the grant.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           resetn,
  mux4_rr_arbiter_if.slave bus
);

  logic [0:0]         state;
  logic [SEL_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic               m_q;

  logic [SEL_W-1:0]   winner;
  logic               any;
  logic               mux_lo;
  logic               mux_hi;
  logic               mux_y;
  logic               owner_req;
  logic               hold_left;

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  mux2to1 u_mux_lo (.a(bus.data[0]), .b(bus.data[1]), .s(sel_q[0]), .y(mux_lo));
  mux2to1 u_mux_hi (.a(bus.data[2]), .b(bus.data[3]), .s(sel_q[0]), .y(mux_hi));
  mux2to1 u_mux_y  (.a(mux_lo),      .b(mux_hi),      .s(sel_q[1]), .y(mux_y));

  assign owner_req = bus.req[sel_q];
  assign hold_left = hold_cnt < HOLD_W'(MAX_HOLD);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      m_q      <= 1'b0;
    end else begin
      m_q <= (|grant_q) ? mux_y : 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            state    <= GRANT;
            grant_q  <= onehot(winner);
            sel_q    <= winner;
            hold_cnt <= HOLD_W'(1);
          end
        end
        default: begin
          if (owner_req && hold_left) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else begin
            // Release always costs one idle cycle; the owner drops to last rotation priority.
            state    <= IDLE;
            grant_q  <= '0;
            hold_cnt <= '0;
            ptr      <= sel_q + SEL_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.m     = m_q;
  assign bus.busy  = (state == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus a random
// run compared cycle by cycle against a behavioural arbitration model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 when idle), cycles held, next priority.
  int         mo_owner;
  int         mo_cnt;
  int         mo_ptr;
  int         mo_sel;
  logic       mo_m;
  logic [3:0] mo_grant;

  task automatic model_reset();
    mo_owner = -1;
    mo_cnt   = 0;
    mo_ptr   = 0;
    mo_sel   = 0;
    mo_m     = 1'b0;
    mo_grant = 4'b0000;
  endtask

  task automatic model_step();
    logic [3:0] r;
    logic [3:0] d;
    r = bus.req;
    d = bus.data;
    mo_m = (mo_owner >= 0) ? d[mo_sel] : 1'b0;
    if (mo_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (mo_owner < 0 && r[(mo_ptr + k) % 4]) begin
          mo_owner = (mo_ptr + k) % 4;
          mo_sel   = mo_owner;
          mo_cnt   = 1;
        end
      end
    end else if (r[mo_owner] && mo_cnt < MAX_HOLD) begin
      mo_cnt = mo_cnt + 1;
    end else begin
      mo_ptr   = (mo_owner + 1) % 4;
      mo_owner = -1;
      mo_cnt   = 0;
    end
    mo_grant = (mo_owner >= 0) ? 4'(1 << mo_owner) : 4'b0000;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    bus.req  = 4'b0000;
    bus.data = 4'b0000;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    bus.req  = 4'b1111;
    bus.data = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.sel !== 2'd0 || bus.m !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b sel=%0d m=%b busy=%b, expected 0000/0/0/0",
               bus.grant, bus.sel, bus.m, bus.busy);
    end
    resetn = 1'b1;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got grant=%b busy=%b, expected 0001/1", bus.grant, bus.busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req  = 4'b0100;
    bus.data = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.m !== (c > 0)) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got grant=%b sel=%0d m=%b, expected 0100/2/%0d",
                 c, bus.grant, bus.sel, bus.m, (c > 0));
      end
    end
    bus.req = 4'b0000;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'd2 || bus.m !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b busy=%b sel=%0d m=%b, expected 0000/0/2/1",
               bus.grant, bus.busy, bus.sel, bus.m);
    end
    tick();
    n_checks++;
    if (bus.m !== 1'b0 || bus.sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_m_drop: got m=%b sel=%0d, expected 0/2", bus.m, bus.sel);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_checks++;
      if (bus.grant !== order[g]) begin
        n_fail++;
        $display("FAIL rotation_grant[%0d]: got %b expected %b", g, bus.grant, order[g]);
      end
      bus.req = 4'b1111 & ~bus.grant;
      tick();
      n_checks++;
      if (bus.grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL rotation_idle[%0d]: got %b expected 0000", g, bus.grant);
      end
      bus.req = 4'b1111;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] who [3];
    who = '{4'b0001, 4'b0010, 4'b0001};
    do_reset();
    bus.req = 4'b0011;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        n_checks++;
        if (bus.grant !== who[g]) begin
          n_fail++;
          $display("FAIL timeout_hold[%0d][%0d]: got %b expected %b", g, c, bus.grant, who[g]);
        end
      end
      tick();
      n_checks++;
      if (bus.grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL timeout_idle[%0d]: got %b expected 0000", g, bus.grant);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req  = 4'b1000;
    bus.data = 4'b1000;
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (bus.grant !== 4'b1000 || bus.m !== 1'b1 || bus.sel !== 2'd3) begin
      n_fail++;
      $display("FAIL resetmid_pre: got grant=%b m=%b sel=%0d, expected 1000/1/3", bus.grant, bus.m, bus.sel);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.m !== 1'b0 || bus.sel !== 2'd0) begin
      n_fail++;
      $display("FAIL resetmid_async: got grant=%b busy=%b m=%b sel=%0d, expected 0000/0/0/0",
               bus.grant, bus.busy, bus.m, bus.sel);
    end
    tick();
    resetn  = 1'b1;
    bus.req = 4'b1001;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL resetmid_ptr: got %b expected 0001", bus.grant);
    end
  endtask

  task automatic test_non_owner();
    do_reset();
    bus.req = 4'b0010;
    tick();
    tick();
    bus.req = 4'b0011;
    tick();
    n_checks++;
    if (bus.grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL nonowner_pulse: got %b expected 0010", bus.grant);
    end
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nonowner_latched: got grant=%b busy=%b, expected 0000/0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.data = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (bus.grant !== mo_grant || bus.sel !== 2'(mo_sel) || bus.m !== mo_m) begin
        n_fail++;
        $display("FAIL random_model[%0d]: got grant=%b sel=%0d m=%b, expected %b/%0d/%b",
                 c, bus.grant, bus.sel, bus.m, mo_grant, mo_sel, mo_m);
      end
      n_checks++;
      if (!$onehot0(bus.grant) || bus.busy !== (|bus.grant) ||
          (bus.busy && bus.grant[bus.sel] !== 1'b1)) begin
        n_fail++;
        $display("FAIL random_invariant[%0d]: got grant=%b busy=%b sel=%0d", c, bus.grant, bus.busy, bus.sel);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_reset_mid();
    test_non_owner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
